// File: rtl/cell_stim_pkg.sv
// Shared types and constants for the standard-cell stimulus sequencer.
// Holds the FSM state encoding, the Gray-code helper and the default OAI222 truth table.
package cell_stim_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_SAMPLE,
    S_FINISH
  } state_e;

  // Bit i is the expected QN of a 6-input OAI222 for input vector i (STIM[0]=IN1 .. STIM[5]=IN6).
  localparam logic [63:0] OAI222_TT = 64'h111F_111F_111F_FFFF;

  localparam int GRAY_W = 16;

  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/stim_settle_timer.sv
// Small down-counter that paces how long each stimulus vector is held before sampling.
// Loaded on entry to the settle phase; o_expire is high once the count has reached zero.
module stim_settle_timer (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [3:0] i_loadVal,
  input  logic       i_en,
  output logic       o_expire
);

  logic [3:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_en && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_expire = (r_count == 4'd0);

endmodule

// File: rtl/cell_stim_sequencer.sv
// Walks every input vector of one combinational cell in binary or Gray order, samples the cell
// output a fixed number of cycles after each update and scores it against a truth-table model.
module cell_stim_sequencer
  import cell_stim_pkg::*;
#(
  parameter int                   N_IN   = 6,
  parameter int                   SETTLE = 2,
  parameter logic [(1<<N_IN)-1:0] TT     = OAI222_TT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_gray,
  output logic [N_IN-1:0] o_stim,
  input  logic            i_dutQ,
  output logic            o_busy,
  output logic            o_done,
  output logic [N_IN:0]   o_errCnt,
  output logic [N_IN:0]   o_tglCnt,
  output logic            o_failValid,
  output logic [N_IN-1:0] o_failVec
);

  localparam int            KW         = N_IN + 1;
  localparam logic [KW-1:0] K_LAST     = KW'((1 << N_IN) - 1);
  localparam logic [3:0]    TIMER_LOAD = 4'(SETTLE >= 2 ? SETTLE - 2 : 0);
  // With a one-cycle settle the SETTLE state would have zero length, so it is skipped entirely.
  localparam bit            HAS_WAIT   = (SETTLE > 1);

  state_e          r_state;
  state_e          w_nextState;
  logic            r_gray;
  logic [KW-1:0]   r_k;
  logic [N_IN-1:0] r_stim;
  logic [KW-1:0]   r_errCnt;
  logic [KW-1:0]   r_tglCnt;
  logic            r_failValid;
  logic [N_IN-1:0] r_failVec;
  logic            r_prevQ;

  logic            w_timerLoad;
  logic            w_timerExpire;
  logic            w_mismatch;
  logic            w_lastVec;
  logic [KW-1:0]   w_kNext;
  logic [N_IN-1:0] w_nextStim;

  stim_settle_timer u_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_timerLoad),
    .i_loadVal (TIMER_LOAD),
    .i_en      (r_state == S_SETTLE),
    .o_expire  (w_timerExpire)
  );

  assign w_kNext    = r_k + KW'(1);
  assign w_lastVec  = (r_k == K_LAST);
  assign w_mismatch = (i_dutQ != TT[r_stim]);
  assign w_nextStim = r_gray ? N_IN'(bin2gray(GRAY_W'(w_kNext))) : N_IN'(w_kNext);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_timerLoad = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_nextState = S_LOAD;
        end
      end
      S_LOAD: begin
        o_busy      = 1'b1;
        w_timerLoad = 1'b1;
        w_nextState = HAS_WAIT ? S_SETTLE : S_SAMPLE;
      end
      S_SETTLE: begin
        o_busy = 1'b1;
        if (w_timerExpire) begin
          w_nextState = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        o_busy = 1'b1;
        if (w_lastVec) begin
          w_nextState = S_FINISH;
        end else begin
          w_timerLoad = 1'b1;
          w_nextState = HAS_WAIT ? S_SETTLE : S_SAMPLE;
        end
      end
      S_FINISH: begin
        o_done      = 1'b1;
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Results are cleared only at LOAD so they stay readable after DONE until the next run.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gray      <= 1'b0;
      r_k         <= '0;
      r_stim      <= '0;
      r_errCnt    <= '0;
      r_tglCnt    <= '0;
      r_failValid <= 1'b0;
      r_failVec   <= '0;
      r_prevQ     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_gray <= i_gray;
          end
        end
        S_LOAD: begin
          r_k         <= '0;
          r_stim      <= '0;
          r_errCnt    <= '0;
          r_tglCnt    <= '0;
          r_failValid <= 1'b0;
          r_failVec   <= '0;
        end
        S_SAMPLE: begin
          if (w_mismatch) begin
            r_errCnt <= r_errCnt + KW'(1);
            if (!r_failValid) begin
              r_failValid <= 1'b1;
              r_failVec   <= r_stim;
            end
          end
          if ((r_k != '0) && (i_dutQ != r_prevQ)) begin
            r_tglCnt <= r_tglCnt + KW'(1);
          end
          r_prevQ <= i_dutQ;
          if (!w_lastVec) begin
            r_k    <= w_kNext;
            r_stim <= w_nextStim;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_stim      = r_stim;
  assign o_errCnt    = r_errCnt;
  assign o_tglCnt    = r_tglCnt;
  assign o_failValid = r_failValid;
  assign o_failVec   = r_failVec;

endmodule

// File: tb/tb_cell_stim_sequencer.sv
// Self-checking bench for cell_stim_sequencer: drives a behavioural OAI222 (plus fault variants)
// on the cell output and scores each run against a vector-list reference model.
module tb_cell_stim_sequencer;

  localparam int N_IN   = 6;
  localparam int NVEC   = 1 << N_IN;
  localparam int SETTLE = 2;
  localparam int LIMIT  = 400;

  logic            clk;
  logic            rst;
  logic            start;
  logic            gray;
  logic            dutQ;
  logic [N_IN-1:0] stim;
  logic [N_IN-1:0] failVec;
  logic            busy;
  logic            done;
  logic            failValid;
  logic [N_IN:0]   errCnt;
  logic [N_IN:0]   tglCnt;

  logic            start1;
  logic            dutQ1;
  logic [N_IN-1:0] stim1;
  logic [N_IN-1:0] failVec1;
  logic            busy1;
  logic            done1;
  logic            failValid1;
  logic [N_IN:0]   errCnt1;
  logic [N_IN:0]   tglCnt1;

  int              qMode;
  logic [NVEC-1:0] faultMask;
  logic            qDly;
  logic            qDly1;

  int nChecks;
  int nFail;

  logic [N_IN-1:0] expVec [NVEC];
  int              expErr;
  int              expTgl;
  bit              expFv;
  logic [N_IN-1:0] expFvec;
  int              expStaleErr;
  int              expStaleTgl;
  logic [N_IN-1:0] expStaleFvec;

  logic [N_IN-1:0] obsVec [NVEC];
  int              obsDoneCycle;
  int              obsBusyDrops;

  cell_stim_sequencer #(.N_IN(N_IN), .SETTLE(SETTLE)) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_gray      (gray),
    .o_stim      (stim),
    .i_dutQ      (dutQ),
    .o_busy      (busy),
    .o_done      (done),
    .o_errCnt    (errCnt),
    .o_tglCnt    (tglCnt),
    .o_failValid (failValid),
    .o_failVec   (failVec)
  );

  cell_stim_sequencer #(.N_IN(N_IN), .SETTLE(1)) u_dut1 (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start1),
    .i_gray      (1'b0),
    .o_stim      (stim1),
    .i_dutQ      (dutQ1),
    .o_busy      (busy1),
    .o_done      (done1),
    .o_errCnt    (errCnt1),
    .o_tglCnt    (tglCnt1),
    .o_failValid (failValid1),
    .o_failVec   (failVec1)
  );

  function automatic logic oai222(input logic [N_IN-1:0] v);
    return ~((v[0] | v[1]) & (v[2] | v[3]) & (v[4] | v[5]));
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cell model with one cycle of output delay, used for the stale-sample scenarios.
  always @(posedge clk) begin
    qDly  <= oai222(stim);
    qDly1 <= oai222(stim1);
  end

  always_comb begin
    case (qMode)
      1:       dutQ = 1'b0;
      2:       dutQ = qDly;
      3:       dutQ = oai222(stim) ^ faultMask[stim];
      default: dutQ = oai222(stim);
    endcase
  end

  assign dutQ1 = qDly1;

  // Reference: list the vectors in order, decide what the cell returns for each, then count.
  task automatic buildModel(input bit g, input int mode);
    logic [N_IN-1:0] v;
    logic            golden;
    logic            q;
    logic            prevQ;
    logic            prevGolden;
    logic            prevStaleQ;
    bit              staleFv;
    expErr = 0; expTgl = 0; expFv = 0; expFvec = '0;
    expStaleErr = 0; expStaleTgl = 0; expStaleFvec = '0; staleFv = 0;
    prevQ = 1'b0; prevStaleQ = 1'b0;
    prevGolden = oai222('0);
    for (int k = 0; k < NVEC; k++) begin
      v = g ? N_IN'(k ^ (k >> 1)) : N_IN'(k);
      expVec[k] = v;
      golden = oai222(v);
      if (mode == 1) q = 1'b0;
      else if (mode == 3) q = golden ^ faultMask[v];
      else q = golden;
      if (q !== golden) begin
        expErr++;
        if (!expFv) begin expFv = 1; expFvec = v; end
      end
      if (k > 0 && q !== prevQ) expTgl++;
      prevQ = q;
      // A one-cycle-short settle sees the previous vector's response.
      if (prevGolden !== golden) begin
        expStaleErr++;
        if (!staleFv) begin staleFv = 1; expStaleFvec = v; end
      end
      if (k > 0 && prevGolden !== prevStaleQ) expStaleTgl++;
      prevStaleQ = prevGolden;
      prevGolden = golden;
    end
  endtask

  // Called at a negedge: pulses START, records STIM at each sample cycle, stops on DONE.
  task automatic runCapture(input bit g, input int againAt);
    int n;
    for (int k = 0; k < NVEC; k++) obsVec[k] = 'x;
    obsDoneCycle = -1;
    obsBusyDrops = 0;
    n = 0;
    gray = g;
    start = 1'b1;
    while (obsDoneCycle < 0 && n < LIMIT) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (againAt > 0 && n == againAt) start = 1'b1;
      if (againAt > 0 && n == againAt + 1) start = 1'b0;
      if (n >= 2 && ((n - 2) % SETTLE) == SETTLE - 1 && ((n - 2) / SETTLE) < NVEC)
        obsVec[(n - 2) / SETTLE] = stim;
      if (done) obsDoneCycle = n;
      else if (!busy) obsBusyDrops++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start1 = 1'b0; gray = 1'b0; qMode = 0; faultMask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    nChecks++; if (stim !== '0) begin nFail++; $display("[TB] FAIL reset_stim: got %0d expected 0", stim); end
    nChecks++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    nChecks++; if (done !== 1'b0) begin nFail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    nChecks++; if (errCnt !== '0) begin nFail++; $display("[TB] FAIL reset_err: got %0d expected 0", errCnt); end
    nChecks++; if (tglCnt !== '0) begin nFail++; $display("[TB] FAIL reset_tgl: got %0d expected 0", tglCnt); end
    nChecks++; if (failValid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_fvalid: got %b expected 0", failValid); end
    nChecks++; if (failVec !== '0) begin nFail++; $display("[TB] FAIL reset_fvec: got %0d expected 0", failVec); end
    rst = 1'b0;
  endtask

  task automatic test_binary();
    @(negedge clk);
    qMode = 0;
    buildModel(1'b0, 0);
    runCapture(1'b0, 0);
    for (int k = 0; k < NVEC; k++) begin
      nChecks++;
      if (obsVec[k] !== expVec[k]) begin nFail++; $display("[TB] FAIL binary_vec[%0d]: got %0d expected %0d", k, obsVec[k], expVec[k]); end
    end
    nChecks++; if (errCnt !== (N_IN+1)'(expErr)) begin nFail++; $display("[TB] FAIL binary_err: got %0d expected %0d", errCnt, expErr); end
    nChecks++; if (tglCnt !== (N_IN+1)'(expTgl)) begin nFail++; $display("[TB] FAIL binary_tgl: got %0d expected %0d", tglCnt, expTgl); end
    nChecks++; if (failValid !== expFv) begin nFail++; $display("[TB] FAIL binary_fvalid: got %b expected %b", failValid, expFv); end
    nChecks++; if (obsDoneCycle != 2 + NVEC * SETTLE) begin nFail++; $display("[TB] FAIL binary_done_cycle: got %0d expected %0d", obsDoneCycle, 2 + NVEC * SETTLE); end
    nChecks++; if (obsBusyDrops != 0) begin nFail++; $display("[TB] FAIL binary_busy: got %0d idle cycles expected 0", obsBusyDrops); end
    @(posedge clk); @(negedge clk);
    nChecks++; if (done !== 1'b0) begin nFail++; $display("[TB] FAIL binary_done_width: got %b expected 0", done); end
  endtask

  task automatic test_gray();
    logic [N_IN-1:0] lastVec;
    @(negedge clk);
    qMode = 0;
    buildModel(1'b1, 0);
    runCapture(1'b1, 0);
    for (int k = 0; k < NVEC; k++) begin
      nChecks++;
      if (obsVec[k] !== expVec[k]) begin nFail++; $display("[TB] FAIL gray_vec[%0d]: got %0d expected %0d", k, obsVec[k], expVec[k]); end
    end
    for (int k = 1; k < NVEC; k++) begin
      nChecks++;
      if ($countones(obsVec[k] ^ obsVec[k-1]) != 1) begin nFail++; $display("[TB] FAIL gray_step[%0d]: got %0d bits changed expected 1", k, $countones(obsVec[k] ^ obsVec[k-1])); end
    end
    lastVec = 6'b100000;
    nChecks++; if (stim !== lastVec) begin nFail++; $display("[TB] FAIL gray_last: got %b expected %b", stim, lastVec); end
    nChecks++; if (errCnt !== (N_IN+1)'(expErr)) begin nFail++; $display("[TB] FAIL gray_err: got %0d expected %0d", errCnt, expErr); end
    nChecks++; if (tglCnt !== (N_IN+1)'(expTgl)) begin nFail++; $display("[TB] FAIL gray_tgl: got %0d expected %0d", tglCnt, expTgl); end
    nChecks++; if (obsDoneCycle != 2 + NVEC * SETTLE) begin nFail++; $display("[TB] FAIL gray_done_cycle: got %0d expected %0d", obsDoneCycle, 2 + NVEC * SETTLE); end
    @(posedge clk); @(negedge clk);
    nChecks++; if (done !== 1'b0) begin nFail++; $display("[TB] FAIL gray_done_width: got %b expected 0", done); end
  endtask

  task automatic test_stuck0();
    @(negedge clk);
    qMode = 1;
    buildModel(1'b0, 1);
    runCapture(1'b0, 0);
    nChecks++; if (errCnt !== (N_IN+1)'(expErr)) begin nFail++; $display("[TB] FAIL stuck0_err: got %0d expected %0d", errCnt, expErr); end
    nChecks++; if (tglCnt !== (N_IN+1)'(expTgl)) begin nFail++; $display("[TB] FAIL stuck0_tgl: got %0d expected %0d", tglCnt, expTgl); end
    nChecks++; if (failValid !== expFv) begin nFail++; $display("[TB] FAIL stuck0_fvalid: got %b expected %b", failValid, expFv); end
    nChecks++; if (failVec !== expFvec) begin nFail++; $display("[TB] FAIL stuck0_fvec: got %0d expected %0d", failVec, expFvec); end
  endtask

  task automatic test_delayed();
    @(negedge clk);
    qMode = 2;
    buildModel(1'b0, 2);
    runCapture(1'b0, 0);
    nChecks++; if (errCnt !== (N_IN+1)'(expErr)) begin nFail++; $display("[TB] FAIL delayed_err: got %0d expected %0d", errCnt, expErr); end
    nChecks++; if (failValid !== expFv) begin nFail++; $display("[TB] FAIL delayed_fvalid: got %b expected %b", failValid, expFv); end
    nChecks++; if (tglCnt !== (N_IN+1)'(expTgl)) begin nFail++; $display("[TB] FAIL delayed_tgl: got %0d expected %0d", tglCnt, expTgl); end
  endtask

  task automatic test_random_faults();
    bit g;
    for (int it = 0; it < 4; it++) begin
      @(negedge clk);
      faultMask = {$urandom, $urandom};
      if (it[0]) faultMask = faultMask & {$urandom, $urandom} & {$urandom, $urandom};
      g = 1'($urandom_range(0, 1));
      qMode = 3;
      buildModel(g, 3);
      runCapture(g, 0);
      nChecks++; if (errCnt !== (N_IN+1)'(expErr)) begin nFail++; $display("[TB] FAIL rand%0d_err: got %0d expected %0d", it, errCnt, expErr); end
      nChecks++; if (tglCnt !== (N_IN+1)'(expTgl)) begin nFail++; $display("[TB] FAIL rand%0d_tgl: got %0d expected %0d", it, tglCnt, expTgl); end
      nChecks++; if (failValid !== expFv) begin nFail++; $display("[TB] FAIL rand%0d_fvalid: got %b expected %b", it, failValid, expFv); end
      nChecks++; if (failVec !== expFvec) begin nFail++; $display("[TB] FAIL rand%0d_fvec: got %0d expected %0d", it, failVec, expFvec); end
      nChecks++; if (obsDoneCycle != 2 + NVEC * SETTLE) begin nFail++; $display("[TB] FAIL rand%0d_done_cycle: got %0d expected %0d", it, obsDoneCycle, 2 + NVEC * SETTLE); end
    end
  endtask

  task automatic test_start_ignored();
    @(negedge clk);
    qMode = 0;
    buildModel(1'b0, 0);
    runCapture(1'b0, 2 + 10 * SETTLE + SETTLE - 1);
    nChecks++; if (errCnt !== (N_IN+1)'(expErr)) begin nFail++; $display("[TB] FAIL restart_err: got %0d expected %0d", errCnt, expErr); end
    nChecks++; if (tglCnt !== (N_IN+1)'(expTgl)) begin nFail++; $display("[TB] FAIL restart_tgl: got %0d expected %0d", tglCnt, expTgl); end
    nChecks++; if (obsDoneCycle != 2 + NVEC * SETTLE) begin nFail++; $display("[TB] FAIL restart_done_cycle: got %0d expected %0d", obsDoneCycle, 2 + NVEC * SETTLE); end
    nChecks++; if (obsBusyDrops != 0) begin nFail++; $display("[TB] FAIL restart_busy: got %0d idle cycles expected 0", obsBusyDrops); end
  endtask

  // Entered on the DONE cycle; the next negedge is the first IDLE cycle.
  task automatic test_back_to_back();
    @(negedge clk);
    qMode = 1;
    buildModel(1'b0, 1);
    runCapture(1'b0, 0);
    nChecks++; if (obsDoneCycle != 2 + NVEC * SETTLE) begin nFail++; $display("[TB] FAIL b2b_done_cycle: got %0d expected %0d", obsDoneCycle, 2 + NVEC * SETTLE); end
    nChecks++; if (errCnt !== (N_IN+1)'(expErr)) begin nFail++; $display("[TB] FAIL b2b_err: got %0d expected %0d", errCnt, expErr); end
    nChecks++; if (failVec !== expFvec) begin nFail++; $display("[TB] FAIL b2b_fvec: got %0d expected %0d", failVec, expFvec); end
  endtask

  task automatic test_reset_abort();
    bit sawDone;
    int bad;
    @(negedge clk);
    qMode = 1;
    gray = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (1 + 20 * SETTLE) @(negedge clk);
    nChecks++; if (stim !== N_IN'(20)) begin nFail++; $display("[TB] FAIL abort_position: got %0d expected 20", stim); end
    rst = 1'b1;
    #1;
    nChecks++; if (stim !== '0) begin nFail++; $display("[TB] FAIL abort_stim: got %0d expected 0", stim); end
    nChecks++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    nChecks++; if (done !== 1'b0) begin nFail++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
    nChecks++; if (errCnt !== '0) begin nFail++; $display("[TB] FAIL abort_err: got %0d expected 0", errCnt); end
    nChecks++; if (tglCnt !== '0) begin nFail++; $display("[TB] FAIL abort_tgl: got %0d expected 0", tglCnt); end
    nChecks++; if (failValid !== 1'b0) begin nFail++; $display("[TB] FAIL abort_fvalid: got %b expected 0", failValid); end
    nChecks++; if (failVec !== '0) begin nFail++; $display("[TB] FAIL abort_fvec: got %0d expected 0", failVec); end
    @(negedge clk);
    rst = 1'b0;
    sawDone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) sawDone = 1;
    end
    nChecks++; if (sawDone) begin nFail++; $display("[TB] FAIL abort_no_done: got activity after reset expected none"); end
    qMode = 0;
    buildModel(1'b0, 0);
    runCapture(1'b0, 0);
    bad = 0;
    for (int k = 0; k < NVEC; k++) if (obsVec[k] !== expVec[k]) bad++;
    nChecks++; if (bad != 0) begin nFail++; $display("[TB] FAIL abort_rerun_vecs: got %0d wrong vectors expected 0", bad); end
    nChecks++; if (errCnt !== (N_IN+1)'(expErr)) begin nFail++; $display("[TB] FAIL abort_rerun_err: got %0d expected %0d", errCnt, expErr); end
    nChecks++; if (tglCnt !== (N_IN+1)'(expTgl)) begin nFail++; $display("[TB] FAIL abort_rerun_tgl: got %0d expected %0d", tglCnt, expTgl); end
    nChecks++; if (failValid !== expFv) begin nFail++; $display("[TB] FAIL abort_rerun_fvalid: got %b expected %b", failValid, expFv); end
    nChecks++; if (obsDoneCycle != 2 + NVEC * SETTLE) begin nFail++; $display("[TB] FAIL abort_rerun_done_cycle: got %0d expected %0d", obsDoneCycle, 2 + NVEC * SETTLE); end
  endtask

  task automatic test_settle1();
    int n;
    @(negedge clk);
    buildModel(1'b0, 0);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 1;
    while (!done1 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    nChecks++; if (n != 2 + NVEC) begin nFail++; $display("[TB] FAIL settle1_done_cycle: got %0d expected %0d", n, 2 + NVEC); end
    nChecks++; if (errCnt1 == '0) begin nFail++; $display("[TB] FAIL settle1_err_nonzero: got %0d expected nonzero", errCnt1); end
    nChecks++; if (errCnt1 !== (N_IN+1)'(expStaleErr)) begin nFail++; $display("[TB] FAIL settle1_err: got %0d expected %0d", errCnt1, expStaleErr); end
    nChecks++; if (tglCnt1 !== (N_IN+1)'(expStaleTgl)) begin nFail++; $display("[TB] FAIL settle1_tgl: got %0d expected %0d", tglCnt1, expStaleTgl); end
    nChecks++; if (failValid1 !== 1'b1) begin nFail++; $display("[TB] FAIL settle1_fvalid: got %b expected 1", failValid1); end
    nChecks++; if (failVec1 !== expStaleFvec) begin nFail++; $display("[TB] FAIL settle1_fvec: got %0d expected %0d", failVec1, expStaleFvec); end
    nChecks++; if (busy1 !== 1'b0) begin nFail++; $display("[TB] FAIL settle1_busy: got %b expected 0", busy1); end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no end of test expected finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    nChecks = 0;
    nFail   = 0;
    test_reset();
    test_binary();
    test_gray();
    test_stuck0();
    test_delayed();
    test_random_faults();
    test_start_ignored();
    test_back_to_back();
    test_reset_abort();
    test_settle1();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
